axis_tx_arbiter: RTL and testbench

Packet-granular round-robin arbiter that shares the single 8-bit UART transmit AXI-Stream channel between several byte-stream requesters, such as the processor output adapter, a status/ack responder and a debug dump source. Each requester sends framed packets delimited by `tlast`. Once a requester is granted, it owns the channel until its `tlast` beat is accepted. The block sits between the requester-side adapters and the UART core's `s_axis_*` port, and adds one output register stage.

---
 rtl/uart_link_pkg.sv | 8 +
 rtl/axis_tx_arbiter_rr_pick.sv | 36 +++
 rtl/axis_tx_arbiter.sv | 115 +++++++++++
 tb/tb_axis_tx_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_link_pkg.sv
// Shared types for the UART link datapath blocks.
package uart_link_pkg;

    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

    localparam int UART_WIDTH = 8;

endpackage

// File: rtl/axis_tx_arbiter_rr_pick.sv
// Round-robin picker: first asserted request scanning upward from ptr+1, wrapping.
// Latency: purely combinational.
// Backpressure: none; callers decide when the pick is used.
module rr_pick #(
    parameter int NUM_PORTS = 2,
    parameter int PTR_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PTR_W-1:0]     ptr,
    output logic [NUM_PORTS-1:0] onehot,
    output logic [PTR_W-1:0]     idx,
    output logic                 any
);

    int               p;
    logic [PTR_W-1:0] sel;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        p      = 0;
        sel    = '0;
        // k = NUM_PORTS lands back on ptr itself, so the last owner is considered last
        for (int k = 1; k <= NUM_PORTS; k++) begin
            p   = (int'(ptr) + k) % NUM_PORTS;
            sel = PTR_W'(p);
            if (!any && req[sel]) begin
                any         = 1'b1;
                idx         = sel;
                onehot[sel] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI-Stream TX channel among requesters.
// Latency: 1 cycle to grant; accepted beats appear on m_axis one cycle later (output register).
// Backpressure: only the owner sees tready, high when the output register is empty or draining.
module axis_tx_arbiter
    import uart_link_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_WIDTH = UART_WIDTH,
    parameter int MAX_BEATS  = 256
) (
    input  logic                            clk,
    input  logic                            arst,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]            s_axis_tlast,
    output logic [NUM_PORTS-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    output logic [NUM_PORTS-1:0]            grant,
    output logic                            busy,
    output logic                            pkt_overflow
);

    localparam int PTR_W = $clog2(NUM_PORTS);
    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    arb_state_t           state, state_nxt;
    logic [PTR_W-1:0]     rr_ptr, own_idx, pick_idx;
    logic [NUM_PORTS-1:0] pick_onehot;
    logic                 pick_any;
    logic [CNT_W-1:0]     beat_cnt;
    logic [DATA_WIDTH-1:0] s_dat [NUM_PORTS];
    logic                 out_free, accept, at_limit, pkt_done, trunc;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_slice
        assign s_dat[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_W     (PTR_W)
    ) u_pick (
        .req    (s_axis_tvalid),
        .ptr    (rr_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign busy = (state == ARB_GRANT);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) state <= ARB_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        s_axis_tready = '0;
        accept        = 1'b0;
        pkt_done      = 1'b0;
        trunc         = 1'b0;
        out_free      = !m_axis_tvalid || m_axis_tready;
        at_limit      = (beat_cnt == CNT_W'(MAX_BEATS - 1));
        case (state)
            ARB_IDLE: begin
                if (pick_any) state_nxt = ARB_GRANT;
            end
            ARB_GRANT: begin
                s_axis_tready[own_idx] = out_free;
                accept   = out_free && s_axis_tvalid[own_idx];
                pkt_done = accept && (s_axis_tlast[own_idx] || at_limit);
                trunc    = accept && at_limit && !s_axis_tlast[own_idx];
                if (pkt_done) state_nxt = ARB_IDLE;
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rr_ptr        <= PTR_W'(NUM_PORTS - 1);
            own_idx       <= '0;
            grant         <= '0;
            beat_cnt      <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            pkt_overflow  <= 1'b0;
        end else begin
            if (state == ARB_IDLE && pick_any) begin
                grant    <= pick_onehot;
                own_idx  <= pick_idx;
                beat_cnt <= '0;
            end
            if (accept) begin
                m_axis_tdata  <= s_dat[own_idx];
                // a packet cut at the beat limit is closed here; the rest re-arbitrates
                m_axis_tlast  <= s_axis_tlast[own_idx] || at_limit;
                m_axis_tvalid <= 1'b1;
                beat_cnt      <= beat_cnt + CNT_W'(1);
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            if (pkt_done) begin
                rr_ptr <= own_idx;
                grant  <= '0;
            end
            if (trunc) pkt_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axis_tx_arbiter.sv
// Directed bench for axis_tx_arbiter: per-port source queues, a packet-level round-robin
// model predicting the beat stream, a per-cycle compare process, and literal sequence checks.
module tb_axis_tx_arbiter;

    localparam int NP   = 3;
    localparam int DW   = 8;
    localparam int MAXB = 4;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    typedef struct {
        int            port;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic             clk  = 1'b0;
    logic             arst = 1'b1;
    logic [NP*DW-1:0] s_axis_tdata  = '0;
    logic [NP-1:0]    s_axis_tvalid = '0;
    logic [NP-1:0]    s_axis_tlast  = '0;
    logic [NP-1:0]    s_axis_tready;
    logic [DW-1:0]    m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tready = 1'b1;
    logic             m_axis_tlast;
    logic [NP-1:0]    grant;
    logic             busy;
    logic             pkt_overflow;

    axis_tx_arbiter #(
        .NUM_PORTS  (NP),
        .DATA_WIDTH (DW),
        .MAX_BEATS  (MAXB)
    ) dut (
        .clk           (clk),
        .arst          (arst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .grant         (grant),
        .busy          (busy),
        .pkt_overflow  (pkt_overflow)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    beat_t         src_q [NP][$];
    exp_t          exp_q [$];
    int            in_idx  = 0;
    int            out_idx = 0;
    logic [DW-1:0] cap_data [$];
    logic          cap_last [$];
    int            cap_port [$];
    int            cap_cyc  [$];
    logic [DW-1:0] want_d [$];
    logic          want_l [$];
    int            want_p [$];
    logic          stall_prev = 1'b0;
    logic [DW:0]   stall_val  = '0;
    logic [NP-1:0] hs;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NP; i++) begin
            if (src_q[i].size() > 0) begin
                s_axis_tvalid[i]         = 1'b1;
                s_axis_tdata[i*DW +: DW] = src_q[i][0].data;
                s_axis_tlast[i]          = src_q[i][0].last;
            end else begin
                s_axis_tvalid[i]         = 1'b0;
                s_axis_tdata[i*DW +: DW] = '0;
                s_axis_tlast[i]          = 1'b0;
            end
        end
    endtask

    // Source side: retire a beat after the edge that accepted it, then present the next.
    always begin
        @(negedge clk);
        hs = s_axis_tvalid & s_axis_tready;
        @(posedge clk);
        #1;
        if (!arst) begin
            for (int i = 0; i < NP; i++)
                if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        end
        drive_inputs();
    end

    // Packet-level model: whole packets granted round-robin after reset, cut at MAXB beats.
    function automatic void build_model();
        beat_t pend [NP][$];
        int    ptr;
        int    p;
        int    n;
        int    left;
        beat_t b;
        exp_t  e;
        exp_q.delete();
        in_idx  = 0;
        out_idx = 0;
        ptr     = NP - 1;
        for (int i = 0; i < NP; i++) pend[i] = src_q[i];
        left = 0;
        for (int i = 0; i < NP; i++) left += pend[i].size();
        while (left > 0) begin
            p = -1;
            for (int k = 1; k <= NP; k++)
                if (p < 0 && pend[(ptr + k) % NP].size() > 0) p = (ptr + k) % NP;
            n = 0;
            e.last = 1'b0;
            while (!e.last && pend[p].size() > 0) begin
                b      = pend[p].pop_front();
                n++;
                left--;
                e.port = p;
                e.data = b.data;
                e.last = b.last || (n == MAXB);
                exp_q.push_back(e);
            end
            ptr = p;
        end
    endfunction

    always @(negedge clk) begin
        if (!arst) begin
            chk("grant_onehot0", 32'($onehot0(grant)), 1);
            chk("ready_outside_grant", 32'(s_axis_tready & ~grant), 0);
            chk("busy_vs_grant", 32'(busy), 32'(grant != '0));
            for (int i = 0; i < NP; i++) begin
                if (s_axis_tvalid[i] && s_axis_tready[i]) begin
                    if (in_idx < exp_q.size()) begin
                        chk("in_port", i, exp_q[in_idx].port);
                        chk("in_data", 32'(s_axis_tdata[i*DW +: DW]), 32'(exp_q[in_idx].data));
                    end else begin
                        chk("in_extra_beat", in_idx, exp_q.size());
                    end
                    cap_port.push_back(i);
                    in_idx++;
                end
            end
            if (stall_prev) begin
                chk("stall_valid", 32'(m_axis_tvalid), 1);
                chk("stall_hold", 32'({m_axis_tlast, m_axis_tdata}), 32'(stall_val));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (out_idx < exp_q.size()) begin
                    chk("out_data", 32'(m_axis_tdata), 32'(exp_q[out_idx].data));
                    chk("out_last", 32'(m_axis_tlast), 32'(exp_q[out_idx].last));
                end else begin
                    chk("out_extra_beat", out_idx, exp_q.size());
                end
                cap_data.push_back(m_axis_tdata);
                cap_last.push_back(m_axis_tlast);
                cap_cyc.push_back(cyc);
                out_idx++;
            end
            stall_prev = m_axis_tvalid && !m_axis_tready;
            stall_val  = {m_axis_tlast, m_axis_tdata};
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic clear_bench();
        for (int i = 0; i < NP; i++) src_q[i].delete();
        exp_q.delete();
        in_idx  = 0;
        out_idx = 0;
        cap_data.delete();
        cap_last.delete();
        cap_port.delete();
        cap_cyc.delete();
        stall_prev = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        arst          = 1'b1;
        m_axis_tready = 1'b1;
        clear_bench();
        repeat (2) @(negedge clk);
        arst = 1'b0;
    endtask

    task automatic push_beat(input int port, input logic [DW-1:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        src_q[port].push_back(b);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (out_idx < exp_q.size() && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk({name, "_all_beats_out"}, out_idx, exp_q.size());
        repeat (4) @(negedge clk);
    endtask

    // Pins both the model's prediction and the captured DUT stream to hand-written values.
    task automatic check_want(input string name);
        chk({name, "_model_len"}, exp_q.size(), want_d.size());
        chk({name, "_dut_len"}, cap_data.size(), want_d.size());
        foreach (want_d[k]) begin
            if (k < exp_q.size()) begin
                chk({name, "_model_data"}, 32'(exp_q[k].data), 32'(want_d[k]));
                chk({name, "_model_last"}, 32'(exp_q[k].last), 32'(want_l[k]));
                chk({name, "_model_port"}, exp_q[k].port, want_p[k]);
            end
            if (k < cap_data.size()) begin
                chk({name, "_dut_data"}, 32'(cap_data[k]), 32'(want_d[k]));
                chk({name, "_dut_last"}, 32'(cap_last[k]), 32'(want_l[k]));
            end
            if (k < cap_port.size()) chk({name, "_dut_port"}, cap_port[k], want_p[k]);
        end
    endtask

    logic bp_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        int n;

        // Reset held for 3 cycles with every requester valid.
        push_beat(0, 8'h30, 1'b1);
        push_beat(1, 8'h31, 1'b1);
        push_beat(2, 8'h32, 1'b1);
        build_model();
        repeat (3) begin
            @(negedge clk);
            chk("reset_outputs",
                32'({m_axis_tvalid, m_axis_tlast, m_axis_tdata, s_axis_tready, grant, busy, pkt_overflow}),
                0);
        end
        arst = 1'b0;
        wait_done("reset_release");
        want_d = '{8'h30, 8'h31, 8'h32};
        want_l = '{1'b1, 1'b1, 1'b1};
        want_p = '{0, 1, 2};
        check_want("reset_release");

        // Simultaneous contention between ports 0 and 1.
        do_reset();
        push_beat(0, 8'h11, 1'b0);
        push_beat(0, 8'h22, 1'b1);
        push_beat(1, 8'hA1, 1'b0);
        push_beat(1, 8'hA2, 1'b0);
        push_beat(1, 8'hA3, 1'b1);
        build_model();
        wait_done("contention");
        want_d = '{8'h11, 8'h22, 8'hA1, 8'hA2, 8'hA3};
        want_l = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        want_p = '{0, 0, 1, 1, 1};
        check_want("contention");
        if (cap_cyc.size() == 5) begin
            chk("contention_in_pkt_gap", cap_cyc[1] - cap_cyc[0], 1);
            chk("contention_bubble", cap_cyc[2] - cap_cyc[1], 2);
            chk("contention_in_pkt_gap2", cap_cyc[3] - cap_cyc[2], 1);
        end

        // Fairness: three ports, two single-beat packets each.
        do_reset();
        push_beat(0, 8'h40, 1'b1);
        push_beat(0, 8'h41, 1'b1);
        push_beat(1, 8'h50, 1'b1);
        push_beat(1, 8'h51, 1'b1);
        push_beat(2, 8'h60, 1'b1);
        push_beat(2, 8'h61, 1'b1);
        build_model();
        wait_done("fairness");
        want_d = '{8'h40, 8'h50, 8'h60, 8'h41, 8'h51, 8'h61};
        want_l = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        want_p = '{0, 1, 2, 0, 1, 2};
        check_want("fairness");

        // Backpressure on a 4-beat packet whose tlast coincides with the beat limit.
        do_reset();
        push_beat(2, 8'hC1, 1'b0);
        push_beat(2, 8'hC2, 1'b0);
        push_beat(2, 8'hC3, 1'b0);
        push_beat(2, 8'hC4, 1'b1);
        build_model();
        n = 0;
        while (!m_axis_tvalid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp_first_valid", 32'(m_axis_tvalid), 1);
        for (int k = 0; k < 6; k++) begin
            m_axis_tready = bp_pat[k];
            @(posedge clk);
            #1;
        end
        m_axis_tready = 1'b1;
        wait_done("backpressure");
        want_d = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        want_l = '{1'b0, 1'b0, 1'b0, 1'b1};
        want_p = '{2, 2, 2, 2};
        check_want("backpressure");
        chk("bp_no_overflow", 32'(pkt_overflow), 0);

        // Truncation at the 4-beat limit; the remainder is a new packet.
        do_reset();
        for (int k = 1; k <= 6; k++) push_beat(1, DW'(k), k == 6);
        build_model();
        wait_done("truncation");
        want_d = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        want_l = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        want_p = '{1, 1, 1, 1, 1, 1};
        check_want("truncation");
        chk("trunc_overflow", 32'(pkt_overflow), 1);
        if (cap_cyc.size() == 6) chk("trunc_bubble", cap_cyc[4] - cap_cyc[3], 2);

        // Reset mid-packet: port 0 completes first so rr_ptr would favour port 1 if not reset.
        do_reset();
        push_beat(0, 8'h50, 1'b1);
        for (int k = 1; k <= 5; k++) push_beat(1, DW'(8'h50 + k), k == 5);
        build_model();
        n = 0;
        while (cap_data.size() < 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("midrst_reached_beat2", cap_data.size(), 3);
        #2;
        arst = 1'b1;
        #1;
        chk("midrst_async_outputs",
            32'({m_axis_tvalid, m_axis_tlast, m_axis_tdata, grant, busy, s_axis_tready}), 0);
        clear_bench();
        @(negedge clk);
        @(negedge clk);
        arst = 1'b0;
        push_beat(0, 8'h60, 1'b1);
        push_beat(1, 8'h61, 1'b1);
        build_model();
        wait_done("midrst_restart");
        want_d = '{8'h60, 8'h61};
        want_l = '{1'b1, 1'b1};
        want_p = '{0, 1};
        check_want("midrst_restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks so far", n_chk);
        $fatal(1);
    end

endmodule
